// File: rtl/led_pkg.sv
// Shared definitions for the LED draw engine: op-codes, panel geometry,
// FSM encoding, packed command layout and the clipping helper.
package led_pkg;

  localparam int CMD_FIFO_DEPTH = 8;
  localparam int CMD_FIFO_AW    = 3;
  localparam int PANEL_W        = 32;
  localparam int PANEL_H        = 16;

  localparam logic [1:0] OP_PIXEL  = 2'b00;
  localparam logic [1:0] OP_RECT   = 2'b01;
  localparam logic [1:0] OP_FILL   = 2'b10;
  localparam logic [1:0] OP_COMMIT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_HOLD,
    ST_COMMIT_HI,
    ST_COMMIT_LO
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] x0;
    logic [3:0] y0;
    logic [5:0] w;
    logic [4:0] h;
    logic [2:0] color;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Last covered coordinate of a span, truncated at the panel edge.
  function automatic logic [6:0] clip_end(input logic [6:0] start,
                                          input logic [6:0] len,
                                          input logic [6:0] lim);
    logic [6:0] e;
    e = start + len;
    if (e > lim) e = lim;
    return e - 7'd1;
  endfunction

endpackage

// File: rtl/led_cmd_fifo.sv
// Generic synchronous FIFO; read data is the head entry, valid whenever not empty.
// Writes are dropped while full and reads while empty, so callers may offer freely.
module led_cmd_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_vld,
  output logic [W-1:0]  rd_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          wr_ok, rd_ok;

  assign full   = (level_q == (AW+1)'(DEPTH));
  assign empty  = (level_q == '0);
  assign level  = level_q;
  assign rd_dat = mem_q[rd_ptr_q];

  always_comb begin
    wr_ok    = wr_vld && !full;
    rd_ok    = rd_vld && !empty;
    wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: rtl/led_draw_engine.sv
// Command-driven pixel walker feeding the LED panel; first write 2 edges after accept,
// 2 clocks per pixel; cmd_ready drops only while the command FIFO is full.
module led_draw_engine
  import led_pkg::*;
#(
  parameter int FIFO_DEPTH = CMD_FIFO_DEPTH,
  parameter int FIFO_AW    = CMD_FIFO_AW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [4:0]         cmd_x0,
  input  logic [3:0]         cmd_y0,
  input  logic [5:0]         cmd_w,
  input  logic [4:0]         cmd_h,
  input  logic [2:0]         cmd_color,
  output logic [4:0]         x_address,
  output logic [3:0]         y_address,
  output logic [2:0]         color,
  output logic               new_data,
  output logic               update_panel,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [7:0]         frame_count
);

  cmd_t           cmd_in, head;
  logic           fifo_full, fifo_empty, push, pop;
  logic [FIFO_AW:0] level_nxt;

  state_t     state_q, state_d;
  logic [6:0] cx_q, cx_d, cy_q, cy_d;
  logic [6:0] x0_q, x0_d, xe_q, xe_d, ye_q, ye_d;
  logic [2:0] col_q, col_d;
  logic       cnt_q, cnt_d;
  logic [6:0] lx0, ly0, lw, lh;

  logic [4:0] x_address_q, x_address_d;
  logic [3:0] y_address_q, y_address_d;
  logic [2:0] color_q, color_d;
  logic       new_data_q, new_data_d;
  logic       update_panel_q, update_panel_d;
  logic       busy_q, busy_d;
  logic [7:0] frame_count_q, frame_count_d;

  assign cmd_in = {cmd_op, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color};
  assign cmd_ready = !fifo_full;
  assign push = cmd_valid && cmd_ready;
  assign pop  = (state_q == ST_LOAD);

  led_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (cmd_valid),
    .wr_dat  (cmd_in),
    .rd_vld  (pop),
    .rd_dat  (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d       = state_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    x0_d          = x0_q;
    xe_d          = xe_q;
    ye_d          = ye_q;
    col_d         = col_q;
    cnt_d         = cnt_q;
    frame_count_d = frame_count_q;
    lx0 = '0;
    ly0 = '0;
    lw  = '0;
    lh  = '0;

    // Normalise every drawing op to a box: PIXEL is 1x1, FILL is the whole panel.
    case (head.op)
      OP_PIXEL: begin lx0 = {2'b0, head.x0}; ly0 = {3'b0, head.y0}; lw = 7'd1; lh = 7'd1; end
      OP_RECT:  begin lx0 = {2'b0, head.x0}; ly0 = {3'b0, head.y0};
                      lw = {1'b0, head.w}; lh = {2'b0, head.h}; end
      OP_FILL:  begin lw = 7'(PANEL_W); lh = 7'(PANEL_H); end
      default:  ;
    endcase

    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD: begin
        if (head.op == OP_COMMIT) begin
          state_d = ST_COMMIT_HI;
          cnt_d   = 1'b0;
        end else if (lw != '0 && lh != '0) begin
          state_d = ST_EMIT;
          cx_d    = lx0;
          cy_d    = ly0;
          x0_d    = lx0;
          xe_d    = clip_end(lx0, lw, 7'(PANEL_W));
          ye_d    = clip_end(ly0, lh, 7'(PANEL_H));
          col_d   = head.color;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: state_d = ST_HOLD;
      ST_HOLD: begin
        if (cx_q == xe_q) begin
          if (cy_q == ye_q) begin
            state_d = ST_IDLE;
          end else begin
            cx_d    = x0_q;
            cy_d    = cy_q + 7'd1;
            state_d = ST_EMIT;
          end
        end else begin
          cx_d    = cx_q + 7'd1;
          state_d = ST_EMIT;
        end
      end
      ST_COMMIT_HI: begin
        if (cnt_q) begin
          state_d = ST_COMMIT_LO;
          cnt_d   = 1'b0;
        end else begin
          cnt_d = 1'b1;
        end
      end
      ST_COMMIT_LO: begin
        if (cnt_q) begin
          state_d       = ST_IDLE;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          cnt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output registers follow the next state so strobes line up with EMIT/COMMIT_HI.
    x_address_d    = x_address_q;
    y_address_d    = y_address_q;
    color_d        = color_q;
    new_data_d     = (state_d == ST_EMIT);
    update_panel_d = (state_d == ST_COMMIT_HI);
    if (state_d == ST_EMIT) begin
      x_address_d = cx_d[4:0];
      y_address_d = cy_d[3:0];
      color_d     = col_d;
    end
    level_nxt = fifo_level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    busy_d    = (state_d != ST_IDLE) || (level_nxt != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cx_q           <= '0;
      cy_q           <= '0;
      x0_q           <= '0;
      xe_q           <= '0;
      ye_q           <= '0;
      col_q          <= '0;
      cnt_q          <= 1'b0;
      x_address_q    <= '0;
      y_address_q    <= '0;
      color_q        <= '0;
      new_data_q     <= 1'b0;
      update_panel_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      x0_q           <= x0_d;
      xe_q           <= xe_d;
      ye_q           <= ye_d;
      col_q          <= col_d;
      cnt_q          <= cnt_d;
      x_address_q    <= x_address_d;
      y_address_q    <= y_address_d;
      color_q        <= color_d;
      new_data_q     <= new_data_d;
      update_panel_q <= update_panel_d;
      busy_q         <= busy_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign x_address    = x_address_q;
  assign y_address    = y_address_q;
  assign color        = color_q;
  assign new_data     = new_data_q;
  assign update_panel = update_panel_q;
  assign busy         = busy_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_led_draw_engine.sv
// Directed bench for led_draw_engine: pixel/rect/commit/fill sequencing, backpressure, reset.
module tb_led_draw_engine;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [4:0] cmd_x0 = '0;
  logic [3:0] cmd_y0 = '0;
  logic [5:0] cmd_w = '0;
  logic [4:0] cmd_h = '0;
  logic [2:0] cmd_color = '0;
  logic [4:0] x_address;
  logic [3:0] y_address;
  logic [2:0] color;
  logic       new_data, update_panel, busy;
  logic [3:0] fifo_level;
  logic [7:0] frame_count;

  led_draw_engine dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .x_address(x_address), .y_address(y_address), .color(color),
    .new_data(new_data), .update_panel(update_panel), .busy(busy),
    .fifo_level(fifo_level), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pv[$];
  int pcyc[$];
  int up_cnt = 0, up_rise = 0, overlap = 0, hold_err = 0;
  int last_acc = 0, idle_cyc = 0;
  bit prev_nd = 0, prev_up = 0;
  logic [11:0] prev_pix = '0;

  function automatic int pk(input int x, input int y, input int c);
    return (x << 7) | (y << 3) | c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor samples 1ns after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!reset_n) begin
      prev_nd = 0;
      prev_up = 0;
    end else begin
      if (new_data && update_panel) overlap++;
      if (prev_nd && (new_data || {x_address, y_address, color} != prev_pix)) hold_err++;
      if (new_data) begin
        pv.push_back(pk(int'(x_address), int'(y_address), int'(color)));
        pcyc.push_back(cyc);
      end
      if (update_panel) begin
        up_cnt++;
        if (!prev_up) up_rise = cyc;
      end
      prev_nd  = new_data;
      prev_up  = update_panel;
      prev_pix = {x_address, y_address, color};
    end
  end

  task automatic clear_mon();
    pv.delete();
    pcyc.delete();
    up_cnt = 0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] op, input int x0, input int y0,
                      input int w, input int h, input int c);
    int n;
    n = 0;
    cmd_op = op; cmd_x0 = x0[4:0]; cmd_y0 = y0[3:0];
    cmd_w = w[5:0]; cmd_h = h[4:0]; cmd_color = c[2:0];
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("accept_timeout", n, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", n, 0);
    idle_cyc = cyc;
  endtask

  task automatic chk_pix(input string tag, input int idx, input int exp);
    if (pv.size() > idx) chk(tag, pv[idx], exp);
    else chk({tag, "_missing"}, pv.size(), idx + 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc9, bad;

    // 1: reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_new_data", new_data, 0);
    chk("rst_update_panel", update_panel, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2: single pixel
    clear_mon();
    send(OP_PIXEL, 5, 3, 0, 0, 5);
    acc = last_acc;
    wait_idle();
    chk("pix_count", pv.size(), 1);
    chk_pix("pix_value", 0, pk(5, 3, 5));
    if (pcyc.size() > 0) chk("pix_latency", pcyc[0] - acc, 2);
    chk("pix_busy_drop", idle_cyc - acc, 4);

    // 3: clipped rect then an empty rect
    clear_mon();
    send(OP_RECT, 30, 14, 4, 4, 2);
    acc = last_acc;
    wait_idle();
    chk("rect_count", pv.size(), 4);
    chk_pix("rect_p0", 0, pk(30, 14, 2));
    chk_pix("rect_p1", 1, pk(31, 14, 2));
    chk_pix("rect_p2", 2, pk(30, 15, 2));
    chk_pix("rect_p3", 3, pk(31, 15, 2));
    for (int i = 1; i < pcyc.size(); i++) chk("rect_spacing", pcyc[i] - pcyc[i-1], 2);
    chk("rect_duration", idle_cyc - acc, 10);
    clear_mon();
    send(OP_RECT, 4, 4, 0, 3, 7);
    acc = last_acc;
    wait_idle();
    chk("rect_w0_count", pv.size(), 0);
    chk("rect_w0_duration", idle_cyc - acc, 2);

    // 4: commit timing, then commit followed immediately by a pixel
    clear_mon();
    send(OP_COMMIT, 0, 0, 0, 0, 0);
    acc = last_acc;
    wait_idle();
    chk("commit_hi_cycles", up_cnt, 2);
    chk("commit_rise", up_rise - acc, 2);
    chk("commit_duration", idle_cyc - acc, 6);
    chk("frame_count_1", frame_count, 1);
    chk("commit_no_write", pv.size(), 0);
    clear_mon();
    send(OP_COMMIT, 0, 0, 0, 0, 0);
    acc = last_acc;
    send(OP_PIXEL, 7, 9, 0, 0, 3);
    wait_idle();
    chk("frame_count_2", frame_count, 2);
    chk("post_commit_pix", pv.size(), 1);
    chk_pix("post_commit_val", 0, pk(7, 9, 3));
    if (pcyc.size() > 0) chk("post_commit_time", pcyc[0] - acc, 8);

    // 5: fill plus nine pixels, FIFO saturates
    clear_mon();
    send(OP_FILL, 0, 0, 0, 0, 6);
    for (int i = 0; i < 8; i++) send(OP_PIXEL, i + 3, i + 2, 0, 0, (i % 7) + 1);
    chk("full_level", fifo_level, 8);
    chk("full_ready", cmd_ready, 0);
    send(OP_PIXEL, 11, 10, 0, 0, 2);
    acc9 = last_acc;
    if (pcyc.size() > 512) chk("p9_accept", acc9 - pcyc[512], 1);
    else chk("p9_accept_early", pcyc.size(), 513);
    wait_idle();
    chk("fill_total", pv.size(), 521);
    bad = 0;
    for (int k = 0; k < 512 && k < pv.size(); k++)
      if (pv[k] != pk(k % 32, k / 32, 6)) bad++;
    chk("fill_order", bad, 0);
    for (int i = 0; i < 9; i++)
      chk_pix("queued_pix", 512 + i, pk(i + 3, i + 2, (i % 7) + 1));

    // 6: reset in the middle of a rect
    clear_mon();
    send(OP_RECT, 0, 0, 32, 1, 7);
    send(OP_PIXEL, 1, 1, 0, 0, 1);
    begin
      int n;
      n = 0;
      while (pv.size() < 10 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) chk("rect10_timeout", n, 0);
    end
    chk("pre_reset_nd", new_data, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_new_data", new_data, 0);
    chk("mid_rst_update", update_panel, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    clear_mon();
    repeat (20) @(negedge clk);
    chk("post_rst_writes", pv.size(), 0);
    chk("post_rst_busy", busy, 0);

    chk("no_overlap", overlap, 0);
    chk("strobe_hold", hold_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
